// File: rtl/row_window_buffer.sv
// Sliding vertical window over a raster stream: ROWS-1 chained line memories
// share one column address, so every output column is aligned without per-row delays.
module row_window_buffer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ROWS           = 5,
  parameter int unsigned MAX_LINE_WIDTH = 1920,
  localparam int unsigned CW = $clog2(MAX_LINE_WIDTH + 1),
  localparam int unsigned LW = $clog2(ROWS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_pixel,
  input  logic                       in_sof,
  input  logic                       in_eol,
  input  logic [CW-1:0]              line_width,
  input  logic                       border_mode,
  output logic                       out_valid,
  output logic [ROWS*DATA_WIDTH-1:0] out_rows,
  output logic [CW-1:0]              out_col,
  output logic                       out_sof,
  output logic                       out_eol,
  output logic [LW-1:0]              out_lines
);

  localparam int unsigned AW = (MAX_LINE_WIDTH > 1) ? $clog2(MAX_LINE_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] mem [ROWS-1][MAX_LINE_WIDTH];
  logic [DATA_WIDTH-1:0] slice [ROWS];
  logic [DATA_WIDTH-1:0] oldest;
  logic [ROWS*DATA_WIDTH-1:0] window;

  logic [CW-1:0] col, col_cur, col_n;
  logic [CW-1:0] eff_width, width_sampled, width_cur;
  logic [LW-1:0] lines, lines_cur, lines_n;
  logic [AW-1:0] addr;
  logic          line_end;

  // Next-state and window assembly; a start-of-frame pixel restarts column and line count.
  always_comb begin
    col_cur       = col;
    lines_cur     = lines;
    width_cur     = eff_width;
    width_sampled = line_width;
    if (line_width == '0 || line_width > CW'(MAX_LINE_WIDTH))
      width_sampled = CW'(MAX_LINE_WIDTH);
    if (in_sof) begin
      col_cur   = '0;
      lines_cur = '0;
      width_cur = width_sampled;
    end

    line_end = in_eol || (col_cur == width_cur - CW'(1));
    col_n    = line_end ? '0 : col_cur + CW'(1);
    lines_n  = lines_cur;
    if (line_end && lines_cur != LW'(ROWS - 1))
      lines_n = lines_cur + LW'(1);

    addr = AW'(col_cur);
    for (int unsigned k = 0; k < ROWS - 1; k++)
      slice[k] = mem[k][addr];
    slice[ROWS-1] = in_pixel;

    oldest = in_pixel;
    for (int unsigned k = 0; k < ROWS; k++)
      if (k + 32'(lines_cur) == ROWS - 1)
        oldest = slice[k];

    // Rows older than the filled history are masked or replicated from the oldest filled row.
    window = '0;
    for (int unsigned k = 0; k < ROWS; k++) begin
      if (k + 32'(lines_cur) >= ROWS - 1)
        window[k*DATA_WIDTH +: DATA_WIDTH] = slice[k];
      else if (border_mode)
        window[k*DATA_WIDTH +: DATA_WIDTH] = oldest;
    end
  end

  // Line memories: read-first, each row shifts one memory older at the current column.
  always_ff @(posedge clk) begin
    if (in_valid)
      for (int unsigned k = 0; k < ROWS - 1; k++)
        mem[k][addr] <= slice[k+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      lines     <= '0;
      eff_width <= CW'(MAX_LINE_WIDTH);
      out_valid <= 1'b0;
      out_rows  <= '0;
      out_col   <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_lines <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        col       <= col_n;
        lines     <= lines_n;
        eff_width <= width_cur;
        out_rows  <= window;
        out_col   <= col_cur;
        out_sof   <= in_sof;
        out_eol   <= in_eol;
        out_lines <= lines_cur;
      end
    end
  end

endmodule

// File: tb/tb_row_window_buffer.sv
// Bench for row_window_buffer: directed frames plus random traffic compared
// against a per-column pixel-history model.
module tb_row_window_buffer;

  localparam int unsigned DW   = 8;
  localparam int unsigned ROWS = 5;
  localparam int unsigned MAXW = 16;
  localparam int unsigned CW   = $clog2(MAXW + 1);
  localparam int unsigned LW   = $clog2(ROWS);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic [DW-1:0]        in_pixel;
  logic                 in_sof;
  logic                 in_eol;
  logic [CW-1:0]        line_width;
  logic                 border_mode;
  logic                 out_valid;
  logic [ROWS*DW-1:0]   out_rows;
  logic [CW-1:0]        out_col;
  logic                 out_sof;
  logic                 out_eol;
  logic [LW-1:0]        out_lines;

  row_window_buffer #(.DATA_WIDTH(DW), .ROWS(ROWS), .MAX_LINE_WIDTH(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_sof(in_sof), .in_eol(in_eol), .line_width(line_width),
    .border_mode(border_mode), .out_valid(out_valid), .out_rows(out_rows),
    .out_col(out_col), .out_sof(out_sof), .out_eol(out_eol), .out_lines(out_lines)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: column position, filled-line count, line width, and per-column history.
  int            m_col, m_lines, m_eff;
  logic [DW-1:0] hist [MAXW][$];

  logic               e_valid, e_sof, e_eol;
  logic [ROWS*DW-1:0] e_rows;
  int                 e_col, e_lines;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_lines = 0; m_eff = MAXW;
  endtask

  task automatic model(input logic [DW-1:0] px, input logic sof, input logic eol,
                       input int lw, input logic bm);
    logic [DW-1:0] w [ROWS];
    if (sof) begin
      m_col = 0; m_lines = 0;
      m_eff = (lw == 0 || lw > MAXW) ? MAXW : lw;
    end
    e_col = m_col; e_lines = m_lines; e_sof = sof; e_eol = eol;
    w[ROWS-1] = px;
    for (int j = 1; j < ROWS; j++)
      w[ROWS-1-j] = (j - 1 < hist[m_col].size()) ? hist[m_col][j-1] : '0;
    for (int r = 0; r < ROWS - 1; r++)
      if (r < ROWS - 1 - m_lines)
        w[r] = bm ? w[ROWS-1-m_lines] : '0;
    for (int r = 0; r < ROWS; r++)
      e_rows[r*DW +: DW] = w[r];
    hist[m_col].push_front(px);
    if (hist[m_col].size() > ROWS - 1) void'(hist[m_col].pop_back());
    if (eol || m_col == m_eff - 1) begin
      m_col = 0;
      if (m_lines < ROWS - 1) m_lines++;
    end else begin
      m_col++;
    end
  endtask

  // One clock: drive at the falling edge, check the registered result at the next falling edge.
  task automatic step(input logic v, input logic [DW-1:0] px, input logic sof,
                      input logic eol, input int lw, input logic bm);
    in_valid = v; in_pixel = px; in_sof = sof; in_eol = eol;
    line_width = CW'(lw); border_mode = bm;
    e_valid = v;
    if (v) model(px, sof, eol, lw, bm);
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    if (e_valid) begin
      chk("out_rows", 64'(out_rows), 64'(e_rows));
      chk("out_col", 64'(out_col), 64'(e_col));
      chk("out_lines", 64'(out_lines), 64'(e_lines));
      chk("out_sof", 64'(out_sof), 64'(e_sof));
      chk("out_eol", 64'(out_eol), 64'(e_eol));
    end
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_rows"}, 64'(out_rows), 64'd0);
    chk({tag, "_col"}, 64'(out_col), 64'd0);
    chk({tag, "_lines"}, 64'(out_lines), 64'd0);
    chk({tag, "_sof"}, 64'(out_sof), 64'd0);
    chk({tag, "_eol"}, 64'(out_eol), 64'd0);
  endtask

  // Six 4-pixel lines, pixel = 16*line + col, optionally with random idle cycles.
  task automatic frame_039(input logic bm, input logic gaps);
    for (int ln = 0; ln < 6; ln++)
      for (int c = 0; c < 4; c++) begin
        if (gaps)
          while ($urandom_range(1) == 1) step(1'b0, DW'($urandom), 1'b0, 1'b0, 4, bm);
        step(1'b1, DW'(16 * ln + c), (ln == 0 && c == 0), 1'b0, 4, bm);
        if (!bm && ln == 4 && c == 2) begin
          chk("req039_rows", 64'(out_rows), 64'h42_32_22_12_02);
          chk("req039_lines", 64'(out_lines), 64'd4);
        end
        if (ln == 1 && c == 3) begin
          chk("req040_rows", 64'(out_rows), bm ? 64'h13_03_03_03_03 : 64'h13_03_00_00_00);
          chk("req040_lines", 64'(out_lines), 64'd1);
        end
      end
  endtask

  logic [DW-1:0] px;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pixel = '0; in_sof = 1'b0; in_eol = 1'b0;
    line_width = '0; border_mode = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Fill every column of every line memory with known data.
    for (int ln = 0; ln < ROWS; ln++)
      for (int c = 0; c < MAXW; c++)
        step(1'b1, DW'($urandom), (ln == 0 && c == 0), 1'b0, MAXW, 1'b0);

    frame_039(1'b0, 1'b0);
    frame_039(1'b1, 1'b0);
    frame_039(1'b0, 1'b1);

    // Early end of line at column 2, then a full line.
    for (int c = 0; c < 4; c++) step(1'b1, DW'(8'h80 + c), (c == 0), 1'b0, 4, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b1, DW'(8'h90 + c), 1'b0, (c == 2), 4, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(1'b1, DW'(8'hA0 + c), 1'b0, 1'b0, 4, 1'b0);
      chk("req042_col", 64'(out_col), 64'(c));
      chk("req042_lines", 64'(out_lines), 64'd2);
    end

    // New frame after three lines masks the stale rows.
    step(1'b1, 8'hEE, 1'b1, 1'b0, 4, 1'b0);
    chk("req043_lines", 64'(out_lines), 64'd0);
    chk("req043_rows", 64'(out_rows[(ROWS-1)*DW-1:0]), 64'd0);

    // Single-pixel line (sof and eol together).
    step(1'b1, 8'h5A, 1'b1, 1'b1, 4, 1'b1);
    step(1'b1, 8'h5B, 1'b0, 1'b0, 4, 1'b1);
    chk("one_pixel_line", 64'(out_lines), 64'd1);

    for (int i = 0; i < 800; i++)
      step(1'($urandom_range(1)), DW'($urandom), ($urandom_range(19) == 0),
           ($urandom_range(9) == 0), int'($urandom_range(20)), 1'($urandom_range(1)));

    // Mid-line reset: outputs clear immediately, the next accept restarts at col 0 / lines 0.
    for (int c = 0; c < 3; c++) step(1'b1, DW'(c), (c == 0), 1'b0, 8, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    px = DW'($urandom);
    step(1'b1, px, 1'b0, 1'b0, 0, 1'b0);
    chk("req044_col", 64'(out_col), 64'd0);
    chk("req044_lines", 64'(out_lines), 64'd0);
    chk("req044_rows", 64'(out_rows), {24'd0, px, 32'd0});
    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(1)), DW'($urandom), 1'b0,
           ($urandom_range(7) == 0), 0, 1'($urandom_range(1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_window_buffer.md
ROW_WINDOW_BUFFER -- requirements
Module: row_window_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter ROWS, default 5, window height; legal values are odd, 3..9.
REQ-003 SHALL have parameter MAX_LINE_WIDTH, default 1920, line-memory depth in pixels.
REQ-004 SHALL define localparam CW = $clog2(MAX_LINE_WIDTH+1) for column-index and width ports.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  pixel qualifier; no backpressure.
REQ-008 in_pixel  input  DATA_WIDTH  newest-row pixel.
REQ-009 in_sof  input  1  start of frame, qualified by in_valid.
REQ-010 in_eol  input  1  end of line, qualified by in_valid; forces an early line end.
REQ-011 line_width  input  CW  active pixels per line; sampled only on an accepted in_sof pixel.
REQ-012 border_mode  input  1  0 = zero-fill unfilled rows; 1 = replicate the nearest filled row.
REQ-013 out_valid  output  1  window column valid.
REQ-014 out_rows  output  ROWS*DATA_WIDTH  packed window column; slice 0 = oldest row, slice ROWS-1 = newest row.
REQ-015 out_col  output  CW  column index of the out_rows column.
REQ-016 out_sof, out_eol  output  1 each  in_sof and in_eol, delayed to align with out_rows.
REQ-017 out_lines  output  $clog2(ROWS)  count of filled history rows at the time of output, 0..ROWS-1.

Function
REQ-018 Accept = in_valid high on a rising edge; state SHALL change only on accept, except for reset.
REQ-019 Storage SHALL be ROWS-1 read-first line memories of MAX_LINE_WIDTH x DATA_WIDTH, each addressed by the same column counter col.
REQ-020 On accept, memory k SHALL read old data at col and write: in_pixel for k = ROWS-2; otherwise the old data read from memory k+1 in the same cycle.
REQ-021 Rows SHALL be column-aligned by the common addressing above; no per-row delay pipelines SHALL be used.
REQ-022 Latency: out_* SHALL be registered exactly 1 cycle after accept; out_valid SHALL be low in any cycle that follows a non-accept cycle.
REQ-023 col SHALL reset to 0 on accepted in_sof, applied to that same pixel.
REQ-024 col SHALL increment per accept and wrap to 0 after col == eff_width-1 or an accepted in_eol, whichever comes first.
REQ-025 eff_width SHALL be the sampled line_width, with 0 or any value > MAX_LINE_WIDTH treated as MAX_LINE_WIDTH; before the first in_sof, eff_width SHALL equal MAX_LINE_WIDTH.
REQ-026 lines register: an accepted in_sof SHALL make lines = 0 for that pixel.
REQ-027 lines SHALL increment at each line end (REQ-024 wrap) and saturate at ROWS-1.
REQ-028 Row slice r SHALL be filled when r >= ROWS-1-lines, and slice ROWS-1 SHALL always be filled.
REQ-029 An unfilled slice SHALL output 0 when border_mode = 0.
REQ-030 An unfilled slice SHALL output slice ROWS-1-lines (the oldest filled row) when border_mode = 1.
REQ-031 border_mode SHALL be sampled per accept.
REQ-032 An accept with both in_sof and in_eol SHALL be a 1-pixel line: out_lines = 0 and out_col = 0, then lines = 1 and col = 0.
REQ-033 out_col and out_lines SHALL report the pre-update col and lines used for that pixel.
REQ-034 Memory contents from a previous frame SHALL remain stored but SHALL be masked per REQ-028..REQ-030.

Reset
REQ-035 On rst_n low, asynchronously: out_valid, out_sof, out_eol, out_rows, out_col, out_lines, col and lines SHALL all be 0.
REQ-036 On rst_n low, eff_width SHALL become MAX_LINE_WIDTH.
REQ-037 Line memories SHALL NOT be reset.
REQ-038 Reset mid-frame SHALL abandon the frame; the first accept after reset SHALL be treated as col = 0, lines = 0.

Verification
REQ-039 ROWS=5, line_width=4, border_mode=0, pixel = 16*line+col, 6 lines -> line 4 col 2 gives out_rows = {0x02,0x12,0x22,0x32,0x42}, oldest first, out_lines=4.
REQ-040 Same stimulus, border_mode=1 -> line 1 col 3 gives {0x03,0x03,0x03,0x03,0x13}, out_lines=1; border_mode=0 gives {0,0,0,0x03,0x13}.
REQ-041 in_valid toggling randomly (50% duty) -> windows identical to REQ-039 and out_valid pulses exactly one cycle after each accept.
REQ-042 in_eol at col 2 with line_width=4 -> col wraps to 0 and lines increments; the next line's out_col sequence is 0,1,2,3.
REQ-043 New in_sof after 3 lines -> out_lines=0 and rows 0..3 are zero (border_mode=0) despite stale memory data.
REQ-044 rst_n pulsed mid-line -> all outputs 0 immediately; the next accept shows out_col=0 and out_lines=0.
